// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: nibble-serial WIDTH-bit adder with valid/ready handshakes
//
// Adds two WIDTH-bit operands one nibble per clock through a shared 4-bit
// ripple slice built from four full_adder cells, LSB nibble first, with the
// inter-nibble carry held in a register.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand pair offered        in_ready  block can accept operands
//   a, b      WIDTH-bit operands          sub       1 = a - b (NSA_SUB_EN only)
//   out_valid result held on sum/cout     out_ready consumer accepts result
//   sum       registered WIDTH-bit result cout      registered final carry
//   busy      high while RUN or DONE
//
// Configuration macro NSA_SUB_EN: when defined, sub selects two's-complement
// subtraction; when undefined the block is add-only and sub is ignored.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CW-1:0]    nib_cnt;
    logic [3:0]       sa, sb, ss;
    logic [4:0]       c;
    logic             sub_en;

`ifdef NSA_SUB_EN
    assign sub_en = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_en     = 1'b0;
`endif

    // Nibble select: bit offset is nib_cnt * 4.
    assign sa   = a_q[{nib_cnt, 2'b00} +: 4];
    assign sb   = b_q[{nib_cnt, 2'b00} +: 4];
    assign c[0] = carry_q;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        full_adder u_fa (
            .x  (sa[i]),
            .y  (sb[i]),
            .ci (c[i]),
            .s  (ss[i]),
            .co (c[i+1])
        );
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            nib_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry.
                    a_q     <= a;
                    b_q     <= sub_en ? ~b : b;
                    carry_q <= sub_en;
                    nib_cnt <= '0;
                    sum     <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    sum[{nib_cnt, 2'b00} +: 4] <= ss;
                    carry_q                    <= c[4];
                    if (nib_cnt == CW'(NIB - 1)) begin
                        cout    <= c[4];
                        nib_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
